// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment encoding is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    // Binary-to-BCD converter states
    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } bcd_state_e;

    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Hex glyphs 0-9, A, b, C, d, E, F; entry 0 is the rightmost element
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // ceil(w * log10(2)) in fixed point; exact for the supported widths
    function automatic int unsigned bcd_digits(input int unsigned w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// start is honoured only in StIdle; done pulses for the single StDone cycle
// while bcd holds the finished result.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int unsigned VAL_W   = 16,
    parameter int unsigned BCD_DIG = bcd_digits(VAL_W)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [VAL_W-1:0]     bin,
    output logic                 busy,
    output logic [4*BCD_DIG-1:0] bcd,
    output logic                 done
);

    localparam int unsigned CNT_W = $clog2(VAL_W);

    bcd_state_e                     state_q, state_d;
    logic [CNT_W-1:0]               cnt_q;
    logic [VAL_W-1:0]               bin_q;
    logic [4*BCD_DIG-1:0]           bcd_q;
    logic [4*BCD_DIG-1:0]           bcd_adj;
    logic [4*BCD_DIG+VAL_W-1:0]     shifted;
    logic                           last_iter;

    assign last_iter = (cnt_q == CNT_W'(VAL_W - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (last_iter) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

    // Add-3 correction on every BCD nibble that would overflow when doubled
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(BCD_DIG); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {bcd_adj, bin_q} << 1;

    // Shift datapath: capture on start, one dabble step per StShift cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            bin_q <= '0;
            bcd_q <= '0;
        end else if (state_q == StIdle && start) begin
            cnt_q <= '0;
            bin_q <= bin;
            bcd_q <= '0;
        end else if (state_q == StShift) begin
            cnt_q <= cnt_q + CNT_W'(1);
            bin_q <= shifted[VAL_W-1:0];
            bcd_q <= shifted[4*BCD_DIG+VAL_W-1:VAL_W];
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment driver: hex or decimal display of a loaded value,
// leading-zero blanking, overflow dashes, arbitrary digit count.
// Optional feature macro: SEG7_DP_EN adds the dp_mask input for decimal points.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIG = 4,
    parameter int unsigned VAL_W = 16,
    parameter int unsigned DIV_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VAL_W-1:0] value,
    input  logic             load,
    input  logic             dec_mode,
    input  logic             blank_en,
`ifdef SEG7_DP_EN
    input  logic [N_DIG-1:0] dp_mask,
`endif
    output logic             busy,
    output logic [7:0]       leds,
    output logic [N_DIG-1:0] ct
);

    localparam int unsigned BCD_DIG = bcd_digits(VAL_W);
    localparam int unsigned EXT_DIG = (BCD_DIG > N_DIG) ? BCD_DIG : N_DIG;
    localparam int unsigned IDX_W   = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    logic [DIV_W-1:0]     presc_q;
    logic [IDX_W-1:0]     idx_q;
    logic [4*N_DIG-1:0]   disp_q;
    logic                 ovf_q;
    logic [7:0]           leds_q, leds_d;
    logic [N_DIG-1:0]     ct_q, ct_d;

    logic                 conv_start, conv_busy, conv_done, hex_load;
    logic [4*BCD_DIG-1:0] conv_bcd;
    logic [4*EXT_DIG-1:0] bcd_ext;
    logic [4*N_DIG-1:0]   hex_val, dec_val;
    logic                 dec_ovf;
    logic [4*N_DIG-1:0]   cur;
    logic                 dp_bit;

    assign busy       = conv_busy;
    assign hex_load   = load & ~dec_mode & ~conv_busy;
    assign conv_start = load &  dec_mode & ~conv_busy;

    bin2bcd_seq #(
        .VAL_W   (VAL_W),
        .BCD_DIG (BCD_DIG)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (value),
        .busy  (conv_busy),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    // Fit the raw value and the BCD result to the display width
    if (VAL_W >= 4 * N_DIG) begin : g_hex_trunc
        assign hex_val = value[4*N_DIG-1:0];
    end else begin : g_hex_pad
        assign hex_val = {{(4*N_DIG-VAL_W){1'b0}}, value};
    end

    if (BCD_DIG >= N_DIG) begin : g_bcd_full
        assign bcd_ext = conv_bcd;
    end else begin : g_bcd_pad
        assign bcd_ext = {{(4*(N_DIG-BCD_DIG)){1'b0}}, conv_bcd};
    end

    assign dec_val = bcd_ext[4*N_DIG-1:0];
    assign dec_ovf = |(bcd_ext >> (4 * N_DIG));

    // Display register, written whole so a partial result is never visible
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else if (conv_done) begin
            disp_q <= dec_val;
            ovf_q  <= dec_ovf;
        end else if (hex_load) begin
            disp_q <= hex_val;
            ovf_q  <= 1'b0;
        end
    end

    // Free-running prescaler; the digit index advances on each wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_q + DIV_W'(1);
            if (presc_q == '1) begin
                idx_q <= (idx_q == IDX_W'(N_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

`ifdef SEG7_DP_EN
    assign dp_bit = dp_mask[idx_q];
`else
    assign dp_bit = 1'b0;
`endif

    // Segment/cathode next values for the active digit
    always_comb begin
        // Active digit in the low nibble; zero means it and all higher digits are 0
        cur  = disp_q >> {idx_q, 2'b00};
        ct_d = ~(N_DIG'(1) << idx_q);
        if (ovf_q) begin
            leds_d = {1'b0, SEG_DASH};
        end else if (blank_en && (idx_q != '0) && (cur == '0)) begin
            leds_d = {dp_bit, SEG_BLANK};
        end else begin
            leds_d = {dp_bit, SEG_LUT[cur[3:0]]};
        end
    end

    // Register segments and cathodes together so they switch on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_q <= '0;
            ct_q   <= '1;
        end else begin
            leds_q <= leds_d;
            ct_q   <= ct_d;
        end
    end

    assign leds = leds_q;
    assign ct   = ct_q;

endmodule
